// File: rtl/boot_pkg.sv
// Shared types and default parameter values for the serial boot loader.
package boot_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_ADDR_W      = 12;
   localparam int DEF_START_ADDR  = 0;
   localparam int DEF_DEPTH       = 4096;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_TIMEOUT_CYC = 65536;

endpackage

// File: rtl/serial_boot_loader_if.sv
// Instruction-memory write port of the boot loader.
// Handshake: wr_en is a one-cycle strobe with no back-pressure; the memory
// must accept wr_data at wr_addr in every cycle where wr_en=1. wr_addr and
// wr_data carry meaning only while wr_en=1.
interface serial_boot_loader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
) ();

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/serial_boot_loader_sync.sv
// Synchroniser chain for an asynchronous strobe plus a rising-edge pulse.
// The pulse is high in the first cycle the synchronised level reads high.
module sync_edge_detect #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic async_in,
   output logic rise
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Metastability chain followed by one delay flop for edge detection.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], async_in};
         prev  <= chain[STAGES-1];
      end
   end

   assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/serial_boot_loader.sv
// Bit-serial boot loader: assembles DATA_W-bit words from an external
// strobe/data pair and writes them to instruction memory at incrementing
// addresses, with idle timeout, end-of-load detection, overflow and checksum.
module serial_boot_loader
   import boot_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int START_ADDR  = DEF_START_ADDR,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic                 ser_clk,
   input  logic                 ser_data,
   serial_boot_loader_if.master mem,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W:0]      word_count,
   output logic [DATA_W-1:0]    checksum,
   output logic                 frame_err,
   output logic                 overflow,
   output state_t               state_dbg
);

   localparam int CNT_W  = $clog2(DATA_W);
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDLE_W-1:0] TO_MAX    = IDLE_W'(TIMEOUT_CYC);
   localparam logic [IDLE_W-1:0] TO_LAST   = IDLE_W'(TIMEOUT_CYC - 1);

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  data_chain;
   logic                    ser_edge;
   logic                    sample;
   logic [DATA_W-2:0]       shift;
   logic [DATA_W-1:0]       word_next;
   logic [CNT_W-1:0]        bit_cnt;
   logic [IDLE_W-1:0]       idle_cnt;
   logic [ADDR_W-1:0]       addr;
   logic                    start, take_bit, last_bit, timeout;

   sync_edge_detect #(.STAGES(SYNC_STAGES)) u_clk_sync (
      .clk      (clk),
      .resetn   (resetn),
      .async_in (ser_clk),
      .rise     (ser_edge)
   );

   // Data chain matches the strobe chain length so the sample lines up with the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) data_chain <= '0;
      else         data_chain <= {data_chain[SYNC_STAGES-2:0], ser_data};
   end

   assign sample    = data_chain[SYNC_STAGES-1];
   assign word_next = {shift, sample};

   assign start    = (state_q == IDLE) && enable;
   assign take_bit = (state_q == RECV) && enable && ser_edge;
   assign last_bit = take_bit && (bit_cnt == LAST_BIT);
   // An edge in the expiry cycle wins, so timeout requires no edge.
   assign timeout  = (state_q == RECV) && enable && !ser_edge && (idle_cnt == TO_LAST);

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: enable low always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (enable) state_d = RECV;
         RECV: begin
            if (!enable)
               state_d = IDLE;
            else if (timeout && bit_cnt == '0 && word_count != '0)
               state_d = DONE;
         end
         DONE: if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: bit assembly, memory write, counters, checksum and sticky flags.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shift       <= '0;
         bit_cnt     <= '0;
         idle_cnt    <= '0;
         addr        <= '0;
         word_count  <= '0;
         checksum    <= '0;
         frame_err   <= 1'b0;
         overflow    <= 1'b0;
         mem.wr_en   <= 1'b0;
         mem.wr_addr <= '0;
         mem.wr_data <= '0;
      end else begin
         mem.wr_en <= 1'b0;
         if (start) begin
            addr       <= ADDR_W'(START_ADDR);
            word_count <= '0;
            checksum   <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
         end else if (take_bit) begin
            shift    <= word_next[DATA_W-2:0];
            idle_cnt <= '0;
            if (last_bit) begin
               bit_cnt <= '0;
               if (word_count < DEPTH_L) begin
                  mem.wr_en   <= 1'b1;
                  mem.wr_addr <= addr;
                  mem.wr_data <= word_next;
                  addr        <= addr + 1'b1;
                  word_count  <= word_count + 1'b1;
                  checksum    <= checksum + word_next;
               end else begin
                  overflow <= 1'b1;
               end
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else if (state_q == RECV && enable) begin
            if (idle_cnt != TO_MAX) idle_cnt <= idle_cnt + 1'b1;
            if (timeout && bit_cnt != '0) begin
               bit_cnt   <= '0;
               frame_err <= 1'b1;
            end
         end
      end
   end

   assign busy      = (state_q == RECV);
   assign done      = (state_q == DONE);
   assign state_dbg = state_q;

endmodule
